// File: rtl/proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_pkg : shared types and IR field helpers for proc_core_param     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package proc_pkg;

  typedef enum logic [2:0] {
    OP_DISP = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SLL  = 3'b110,
    OP_MOVI = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_T1   = 2'd1,
    S_T2   = 2'd2,
    S_T3   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BUS_RX  = 2'd0,
    BUS_G   = 2'd1,
    BUS_IMM = 2'd2
  } bus_sel_t;

  localparam int MAX_IW = 32;

  // IR layout is {op, rx, ry}; rw is the register-index width.
  function automatic opcode_t ir_op(input logic [MAX_IW-1:0] ir, input int rw);
    return opcode_t'(ir[2*rw +: 3]);
  endfunction

  function automatic logic [7:0] ir_rx(input logic [MAX_IW-1:0] ir, input int rw);
    logic [MAX_IW-1:0] v;
    v = (ir >> rw) & ((MAX_IW'(1) << rw) - MAX_IW'(1));
    return v[7:0];
  endfunction

  function automatic logic [7:0] ir_ry(input logic [MAX_IW-1:0] ir, input int rw);
    logic [MAX_IW-1:0] v;
    v = ir & ((MAX_IW'(1) << rw) - MAX_IW'(1));
    return v[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_alu : combinational ALU; all width/wrap/shift rules live here   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int SW = $clog2(DATA_W);

  logic [SW-1:0] w_sh;
  assign w_sh = b[SW-1:0];

  // Results are DATA_W wide, so add/sub/mul wrap and keep the low bits.
  always_comb begin
    y = b;
    case (op)
      OP_ADD, OP_ADDI: y = a + b;
      OP_SUB:          y = a - b;
      OP_MUL:          y = a * b;
      OP_SRL:          y = a >> w_sh;
      OP_SLL:          y = a << w_sh;
      default:         y = b;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/register_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | register_n : W-bit load-enable register, synchronous reset           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module register_n #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sign_extender.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sign_extender : IN_W -> OUT_W two's-complement resize                |
// | Rev 1.1                                                              |
// +----------------------------------------------------------------------+
module sign_extender #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  generate
    if (OUT_W > IN_W) begin : g_extend
      assign out_val = {{(OUT_W-IN_W){in_val[IN_W-1]}}, in_val};
    end else if (OUT_W == IN_W) begin : g_pass
      assign out_val = in_val;
    end else begin : g_trunc
      // Narrow datapaths keep only the low bits of the immediate.
      assign out_val = in_val[OUT_W-1:0];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/proc_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | proc_core_param : parametrised multi-cycle accumulator-style core    |
// | Rev 2.0                                                              |
// +----------------------------------------------------------------------+
module proc_core_param
  import proc_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int NREG   = 8,
  localparam int RW     = $clog2(NREG),
  localparam int IW     = 3 + 2*RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [IW-1:0]     din,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] h_out
);

  state_t            r_state, w_next;
  logic [IW-1:0]     r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_g, r_h;

  opcode_t           w_op;
  logic [RW-1:0]     w_rx, w_ry;
  logic [DATA_W-1:0] w_imm, w_alu_y, w_bus;
  logic [DATA_W-1:0] w_rf [NREG];
  bus_sel_t          w_bus_sel;
  logic              w_ir_ld, w_ab_ld, w_g_ld, w_h_ld, w_rf_we;

  assign w_op = ir_op(32'(r_ir), RW);
  assign w_rx = RW'(ir_rx(32'(r_ir), RW));
  assign w_ry = RW'(ir_ry(32'(r_ir), RW));

  sign_extender #(.IN_W(IW), .OUT_W(DATA_W)) u_sext (
    .in_val  (din),
    .out_val (w_imm)
  );

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_regs
      register_n #(.W(DATA_W)) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (w_rf_we && (w_rx == RW'(i))),
        .d   (w_bus),
        .q   (w_rf[i])
      );
    end
  endgenerate

  always_comb begin
    w_bus = r_g;
    case (w_bus_sel)
      BUS_RX:  w_bus = w_rf[w_rx];
      BUS_IMM: w_bus = w_imm;
      default: w_bus = r_g;
    endcase
  end

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .op (w_op),
    .a  (r_a),
    .b  (r_b),
    .y  (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_bus_sel = BUS_G;
    w_ir_ld   = 1'b0;
    w_ab_ld   = 1'b0;
    w_g_ld    = 1'b0;
    w_h_ld    = 1'b0;
    w_rf_we   = 1'b0;
    done      = 1'b0;
    busy      = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (run) begin
          w_ir_ld = 1'b1;
          w_next  = S_T1;
        end
      end
      S_T1: begin
        case (w_op)
          OP_DISP: begin
            w_bus_sel = BUS_RX;
            w_h_ld    = 1'b1;
            done      = 1'b1;
            w_next    = S_IDLE;
          end
          OP_MOVI: begin
            w_bus_sel = BUS_IMM;
            w_rf_we   = 1'b1;
            done      = 1'b1;
            w_next    = S_IDLE;
          end
          default: begin
            w_bus_sel = BUS_RX;
            w_ab_ld   = 1'b1;
            w_next    = S_T2;
          end
        endcase
      end
      S_T2: begin
        w_g_ld = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        w_bus_sel = BUS_G;
        w_rf_we   = 1'b1;
        done      = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A and B both sample in T1, so rx==ry sees the pre-instruction value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir <= '0;
      r_a  <= '0;
      r_b  <= '0;
      r_g  <= '0;
      r_h  <= '0;
    end else begin
      if (w_ir_ld) r_ir <= din;
      if (w_ab_ld) begin
        r_a <= w_bus;
        r_b <= (w_op == OP_ADDI) ? w_imm : w_rf[w_ry];
      end
      if (w_g_ld) r_g <= w_alu_y;
      if (w_h_ld) r_h <= w_bus;
    end
  end

  assign h_out = r_h;

endmodule
`default_nettype wire

// File: tb/tb_proc_core_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_proc_core_param : randomized bench with instruction-level model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_proc_core_param;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic [8:0]  din = '0;
  logic        done, busy;
  logic [15:0] h_out;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] m_r [8];
  logic [15:0] m_h;

  proc_core_param #(.DATA_W(16), .NREG(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .din   (din),
    .done  (done),
    .busy  (busy),
    .h_out (h_out)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_h = '0;
  endtask

  task automatic model_exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                            input logic [8:0] imm);
    longint a, b, r;
    a = longint'(m_r[rx]);
    b = (op == 3'd2 || op == 3'd7) ? (longint'($signed(imm)) & 64'hFFFF) : longint'(m_r[ry]);
    r = a;
    case (op)
      3'd0: m_h = m_r[rx];
      3'd1, 3'd2: r = (a + b) % 65536;
      3'd3: r = (a - b + 65536) % 65536;
      3'd4: r = (a * b) % 65536;
      3'd5: r = a / (longint'(1) << (b % 16));
      3'd6: r = (a * (longint'(1) << (b % 16))) % 65536;
      default: r = b;
    endcase
    if (op != 3'd0) m_r[rx] = r[15:0];
  endtask

  // Issue one instruction; noise keeps run high through the busy/done cycles.
  task automatic exec(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry,
                      input logic [8:0] imm, input bit noise);
    int lat;
    lat = (op == 3'd0 || op == 3'd7) ? 1 : 3;
    din = {op, rx, ry};
    run = 1'b1;
    @(posedge clk); #1;
    run = noise;
    din = imm;
    for (int n = 1; n <= lat; n++) begin
      vectors++;
      if (done !== (n == lat) || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL tick op=%0d n=%0d: done=%b busy=%b, want done=%b busy=1",
                 op, n, done, busy, (n == lat));
      end
      if (n < lat) begin
        @(posedge clk); #1;
      end
    end
    run = 1'b0;
    model_exec(op, rx, ry, imm);
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || h_out !== m_h) begin
      miscompares++;
      $display("FAIL post op=%0d rx=%0d: done=%b busy=%b h_out=%h, want 0 0 %h",
               op, rx, done, busy, h_out, m_h);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b1;
    din = 9'h1FF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run = 1'b0;
    model_clear();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || h_out !== 16'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b h_out=%h, want 0 0 0000", busy, done, h_out);
    end
  endtask

  task automatic test_directed();
    exec(3'd7, 3'd0, 3'd0, 9'h1FB, 1'b0);   // MOVI R0,-5
    exec(3'd7, 3'd1, 3'd0, 9'h003, 1'b0);   // MOVI R1,3
    exec(3'd1, 3'd0, 3'd1, 9'h000, 1'b0);   // ADD R0,R1
    exec(3'd0, 3'd0, 3'd0, 9'h000, 1'b0);
    vectors++;
    if (h_out !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL add_r0: h_out=%h want FFFE", h_out);
    end
    exec(3'd3, 3'd1, 3'd0, 9'h000, 1'b0);   // SUB R1,R0
    exec(3'd7, 3'd2, 3'd0, 9'h000, 1'b0);
    exec(3'd7, 3'd3, 3'd0, 9'h001, 1'b0);
    exec(3'd3, 3'd2, 3'd3, 9'h000, 1'b0);   // SUB R2,R3 wraps
    exec(3'd0, 3'd2, 3'd0, 9'h000, 1'b0);
    vectors++;
    if (h_out !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL sub_wrap: h_out=%h want FFFF", h_out);
    end
    exec(3'd7, 3'd4, 3'd0, 9'h001, 1'b0);
    exec(3'd7, 3'd7, 3'd0, 9'h008, 1'b0);
    exec(3'd6, 3'd4, 3'd7, 9'h000, 1'b0);   // R4 = 0x0100
    exec(3'd4, 3'd4, 3'd4, 9'h000, 1'b0);   // MUL keeps low bits
    exec(3'd0, 3'd4, 3'd0, 9'h000, 1'b0);
    vectors++;
    if (h_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL mul_low: h_out=%h want 0000", h_out);
    end
    exec(3'd7, 3'd5, 3'd0, 9'h001, 1'b0);
    exec(3'd7, 3'd6, 3'd0, 9'h011, 1'b0);
    exec(3'd6, 3'd5, 3'd6, 9'h000, 1'b0);   // shift 17 -> 1
    exec(3'd0, 3'd5, 3'd0, 9'h000, 1'b0);
    vectors++;
    if (h_out !== 16'h0002) begin
      miscompares++;
      $display("FAIL sll_mod: h_out=%h want 0002", h_out);
    end
    exec(3'd5, 3'd5, 3'd5, 9'h000, 1'b0);
    exec(3'd0, 3'd1, 3'd0, 9'h000, 1'b0);
    vectors++;
    if (h_out !== 16'h0005) begin
      miscompares++;
      $display("FAIL disp_r1: h_out=%h want 0005", h_out);
    end
  endtask

  task automatic test_run_ignored();
    exec(3'd1, 3'd0, 3'd1, 9'h000, 1'b1);
    exec(3'd2, 3'd3, 3'd0, 9'h1F0, 1'b1);
    exec(3'd0, 3'd0, 3'd0, 9'h000, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_hold: busy=%b done=%b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_reset_midflight();
    din = {3'd1, 3'd0, 3'd1};
    run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL t2_state: busy=%b done=%b want 1 0", busy, done);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || h_out !== 16'h0) begin
      miscompares++;
      $display("FAIL mid_reset: busy=%b done=%b h_out=%h want 0 0 0000", busy, done, h_out);
    end
    for (int i = 0; i < 8; i++) begin
      exec(3'd0, 3'(i), 3'd0, 9'h000, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [2:0] op, rx, ry;
    logic [8:0] imm;
    for (int k = 0; k < 24; k++) begin
      exec(3'd7, 3'(k % 8), 3'd0, 9'($urandom), 1'b0);
    end
    for (int k = 0; k < 120; k++) begin
      op  = 3'($urandom_range(0, 7));
      rx  = 3'($urandom);
      ry  = 3'($urandom);
      imm = 9'($urandom);
      exec(op, rx, ry, imm, 1'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      exec(3'd0, 3'(i), 3'd0, 9'h000, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_run_ignored();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
